// File: rtl/elevator_pkg.sv
// Shared constants, state encoding and per-floor helper functions for the
// 4-floor elevator call scheduler.
package elevator_pkg;

   localparam int NUM_FLOORS = 4;
   localparam int FLOOR_W    = $clog2(NUM_FLOORS);

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      MOVE_UP = 2'b01,
      MOVE_DN = 2'b10,
      DOOR    = 2'b11
   } state_t;

   localparam logic DIR_UP = 1'b1;
   localparam logic DIR_DN = 1'b0;

   localparam logic [NUM_FLOORS-1:0] LSB_ONE = {{(NUM_FLOORS-1){1'b0}}, 1'b1};

   function automatic logic is_multi_hot(input logic [NUM_FLOORS-1:0] v);
      return (v & (v - LSB_ONE)) != '0;
   endfunction

   function automatic logic is_onehot(input logic [NUM_FLOORS-1:0] v);
      return (v != '0) && !is_multi_hot(v);
   endfunction

   function automatic logic [FLOOR_W-1:0] floor_index(input logic [NUM_FLOORS-1:0] v);
      logic [FLOOR_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < NUM_FLOORS; i++)
         if (v[i]) idx = FLOOR_W'(i);
      return idx;
   endfunction

   function automatic logic [NUM_FLOORS-1:0] floor_bit(input logic [FLOOR_W-1:0] f);
      logic [NUM_FLOORS-1:0] m;
      m    = '0;
      m[f] = 1'b1;
      return m;
   endfunction

   // Floors strictly above / strictly below f.
   function automatic logic [NUM_FLOORS-1:0] above_mask(input logic [FLOOR_W-1:0] f);
      logic [NUM_FLOORS-1:0] m;
      for (int i = 0; i < NUM_FLOORS; i++)
         m[i] = (i > int'(f));
      return m;
   endfunction

   function automatic logic [NUM_FLOORS-1:0] below_mask(input logic [FLOOR_W-1:0] f);
      logic [NUM_FLOORS-1:0] m;
      for (int i = 0; i < NUM_FLOORS; i++)
         m[i] = (i < int'(f));
      return m;
   endfunction

endpackage

// File: rtl/door_timer.sv
// Door-open dwell counter: loads DOOR_CYCLES-1 on entry or reopen, counts
// down to zero, and reports done when zero is reached without a reopen.
module door_timer #(
   parameter int DOOR_CYCLES = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic load,
   input  logic reload,
   output logic done
);

   localparam logic [7:0] LOAD_VAL = 8'(DOOR_CYCLES - 1);

   logic [7:0] count_reg;

   always_ff @(posedge clk) begin
      if (reset)
         count_reg <= '0;
      else if (load || reload)
         count_reg <= LOAD_VAL;
      else if (count_reg != '0)
         count_reg <= count_reg - 8'd1;
   end

   assign done = (count_reg == '0) && !reload;

endmodule

// File: rtl/elevator_call_scheduler.sv
// Call latching, floor tracking and directional-sweep dispatch FSM for a
// 4-floor elevator; motor/door outputs decode the state register directly.
module elevator_call_scheduler
   import elevator_pkg::*;
#(
   parameter int DOOR_CYCLES = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_FLOORS-1:0] sensor,
   input  logic [NUM_FLOORS-1:0] hall_up,
   input  logic [NUM_FLOORS-1:0] hall_dn,
   input  logic [NUM_FLOORS-1:0] car_btn,
   output logic                  up,
   output logic                  down,
   output logic                  stop,
   output logic                  opendoor,
   output logic [FLOOR_W-1:0]    cur_floor,
   output logic [NUM_FLOORS-1:0] pending,
   output logic                  sensor_err
);

   localparam logic [NUM_FLOORS-1:0] UP_VALID = {1'b0, {(NUM_FLOORS-1){1'b1}}};
   localparam logic [NUM_FLOORS-1:0] DN_VALID = {{(NUM_FLOORS-1){1'b1}}, 1'b0};
   localparam logic [FLOOR_W-1:0]    TOP_FLOOR = FLOOR_W'(NUM_FLOORS - 1);

   state_t                state_reg, state_next;
   logic                  dir_reg, dir_next;
   logic [FLOOR_W-1:0]    cur_floor_reg, dep_floor_reg;
   logic [NUM_FLOORS-1:0] up_q_reg, dn_q_reg, car_q_reg;
   logic [NUM_FLOORS-1:0] up_q_next, dn_q_next, car_q_next;
   logic                  sensor_err_reg;

   logic [NUM_FLOORS-1:0] req, here, up_press, dn_press;
   logic [NUM_FLOORS-1:0] none_above, none_below;
   logic [NUM_FLOORS-1:0] up_clr, dn_clr, car_clr;
   logic                  above, below, sensor_valid;
   logic [FLOOR_W-1:0]    sensor_idx;
   logic                  door_load, door_reload, door_done;

   assign up_press     = hall_up & UP_VALID;
   assign dn_press     = hall_dn & DN_VALID;
   assign req          = up_q_reg | dn_q_reg | car_q_reg;
   assign here         = floor_bit(cur_floor_reg);
   assign above        = |(req & above_mask(cur_floor_reg));
   assign below        = |(req & below_mask(cur_floor_reg));
   assign sensor_valid = is_onehot(sensor);
   assign sensor_idx   = floor_index(sensor);

   generate
      for (genvar gi = 0; gi < NUM_FLOORS; gi++) begin : g_beyond
         assign none_above[gi] = ~|(req & above_mask(FLOOR_W'(gi)));
         assign none_below[gi] = ~|(req & below_mask(FLOOR_W'(gi)));
      end
   endgenerate

   // The hall bit against the travel direction is only answered once nothing lies ahead.
   always_comb begin
      car_clr = '0;
      up_clr  = '0;
      dn_clr  = '0;
      if (state_reg == DOOR) begin
         car_clr = here;
         up_clr  = (dir_reg == DIR_UP || !below) ? here : '0;
         dn_clr  = (dir_reg == DIR_DN || !above) ? here : '0;
      end
   end

   assign up_q_next   = (up_q_reg  | up_press) & ~up_clr;
   assign dn_q_next   = (dn_q_reg  | dn_press) & ~dn_clr;
   assign car_q_next  = (car_q_reg | car_btn)  & ~car_clr;
   assign door_reload = (state_reg == DOOR) && |((up_press | dn_press | car_btn) & here);

   always_comb begin
      state_next = state_reg;
      dir_next   = dir_reg;
      door_load  = 1'b0;
      case (state_reg)
         IDLE: begin
            if (req[cur_floor_reg]) begin
               state_next = DOOR;
               door_load  = 1'b1;
            end else if (above && (dir_reg == DIR_UP || !below)) begin
               state_next = MOVE_UP;
               dir_next   = DIR_UP;
            end else if (below) begin
               state_next = MOVE_DN;
               dir_next   = DIR_DN;
            end
         end
         // Stop decisions use the incoming sensor index, not the registered floor.
         MOVE_UP: begin
            if (sensor_valid && sensor_idx > dep_floor_reg &&
                (car_q_reg[sensor_idx] || up_q_reg[sensor_idx] ||
                 (dn_q_reg[sensor_idx] && none_above[sensor_idx]) ||
                 sensor_idx == TOP_FLOOR)) begin
               state_next = DOOR;
               door_load  = 1'b1;
            end
         end
         MOVE_DN: begin
            if (sensor_valid && sensor_idx < dep_floor_reg &&
                (car_q_reg[sensor_idx] || dn_q_reg[sensor_idx] ||
                 (up_q_reg[sensor_idx] && none_below[sensor_idx]) ||
                 sensor_idx == '0)) begin
               state_next = DOOR;
               door_load  = 1'b1;
            end
         end
         DOOR: begin
            if (door_done)
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg      <= IDLE;
         dir_reg        <= DIR_UP;
         cur_floor_reg  <= '0;
         dep_floor_reg  <= '0;
         up_q_reg       <= '0;
         dn_q_reg       <= '0;
         car_q_reg      <= '0;
         sensor_err_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         dir_reg   <= dir_next;
         up_q_reg  <= up_q_next;
         dn_q_reg  <= dn_q_next;
         car_q_reg <= car_q_next;
         if (sensor_valid)
            cur_floor_reg <= sensor_idx;
         if (is_multi_hot(sensor))
            sensor_err_reg <= 1'b1;
         if (state_reg == IDLE)
            dep_floor_reg <= cur_floor_reg;
      end
   end

   door_timer #(
      .DOOR_CYCLES(DOOR_CYCLES)
   ) u_door_timer (
      .clk   (clk),
      .reset (reset),
      .load  (door_load),
      .reload(door_reload),
      .done  (door_done)
   );

   assign up         = (state_reg == MOVE_UP);
   assign down       = (state_reg == MOVE_DN);
   assign stop       = (state_reg == IDLE) || (state_reg == DOOR);
   assign opendoor   = (state_reg == DOOR);
   assign cur_floor  = cur_floor_reg;
   assign pending    = req;
   assign sensor_err = sensor_err_reg;

endmodule
